// File: rtl/capture_unit.sv
// capture_unit: timestamps selected edges of an asynchronous input against a
// free-running counter and queues {polarity, timestamp} in a small
// first-word-fall-through FIFO drained through a valid/ready handshake.
module capture_unit #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             ena_i,
  input  logic [1:0]       edge_sel_i,
  input  logic             cap_i,
  output logic [WIDTH-1:0] value_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] cap_data_o,
  output logic             cap_edge_o,
  output logic             cap_valid_o,
  input  logic             cap_ready_i,
  output logic             ovf_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SYNC_STAGES + 1);

  // Counter
  logic [WIDTH-1:0] value_reg;
  logic             wrap_reg;

  // Synchronizer, previous-sample flop and settle logic
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic [SW-1:0]          settle_cnt_reg;
  logic                   settle_done_reg;

  // Registered push stage
  logic             push_valid_reg;
  logic             push_edge_reg;
  logic [WIDTH-1:0] push_data_reg;

  // FIFO storage: bit WIDTH holds polarity, the rest the timestamp
  logic [WIDTH:0]   mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             ovf_reg;

  logic sync_s;
  logic rise;
  logic fall;
  logic event_fire;
  logic fifo_full;
  logic pop;
  logic wr_en;

  assign sync_s     = sync_reg[SYNC_STAGES-1];
  assign rise       = sync_s & ~prev_reg;
  assign fall       = ~sync_s & prev_reg;
  assign event_fire = ena_i & settle_done_reg &
                      ((rise & edge_sel_i[0]) | (fall & edge_sel_i[1]));

  assign fifo_full  = (count_reg == CW'(DEPTH));
  assign pop        = cap_valid_o & cap_ready_i;
  // A push into a full FIFO only lands when the head leaves in the same cycle
  assign wr_en      = push_valid_reg & (~fifo_full | pop);

  assign value_o     = value_reg;
  assign wrap_o      = wrap_reg;
  assign cap_valid_o = (count_reg != '0);
  assign {cap_edge_o, cap_data_o} = mem_reg[rd_ptr_reg];
  assign ovf_o       = ovf_reg;

  // Free-running counter with a registered wrap pulse aligned to the 0 value
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      value_reg <= '0;
      wrap_reg  <= 1'b0;
    end else if (ena_i) begin
      value_reg <= value_reg + WIDTH'(1);
      wrap_reg  <= &value_reg;
    end else begin
      wrap_reg  <= 1'b0;
    end
  end

  // Synchronizer chain; keeps running through clr so p never lags s
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], cap_i};
      prev_reg <= sync_s;
    end
  end

  // Suppress events while the chain refills after reset or clear
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      settle_cnt_reg  <= '0;
      settle_done_reg <= 1'b0;
    end else if (!settle_done_reg) begin
      if (settle_cnt_reg == SW'(SYNC_STAGES)) begin
        settle_done_reg <= 1'b1;
      end else begin
        settle_cnt_reg <= settle_cnt_reg + SW'(1);
      end
    end
  end

  // Register the detected event with the counter value of the detection cycle
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      push_valid_reg <= 1'b0;
      push_edge_reg  <= 1'b0;
      push_data_reg  <= '0;
    end else begin
      push_valid_reg <= event_fire;
      push_edge_reg  <= rise;
      push_data_reg  <= value_reg;
    end
  end

  // FIFO storage write; cleared so the head reads 0 after reset or clear
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ptr_reg == AW'(i)) begin
          mem_reg[i] <= {push_edge_reg, push_data_reg};
        end
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (push_valid_reg && fifo_full && !pop) begin
        ovf_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_capture_unit.sv
// tb_capture_unit: scoreboard bench for capture_unit. A behavioural model
// predicts counter, flags and accepted captures; a negedge monitor compares.
module tb_capture_unit;

  localparam int W = 8;
  localparam int D = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst, clr, ena, cap, ready;
  logic [1:0]   esel;
  logic [W-1:0] value, cdata;
  logic         wrap, cedge, cvalid, ovf;

  always #5 clk = ~clk;

  capture_unit #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .ena_i(ena), .edge_sel_i(esel),
    .cap_i(cap), .value_o(value), .wrap_o(wrap), .cap_data_o(cdata),
    .cap_edge_o(cedge), .cap_valid_o(cvalid), .cap_ready_i(ready), .ovf_o(ovf)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic         e;
    logic [W-1:0] ts;
  } ent_t;

  logic [W-1:0] m_cnt = '0;
  bit           m_wrap = 0;
  bit           m_ovf = 0;
  int           m_occ = 0;
  int           m_settle = 0;
  bit           m_samp[$];     // newest input sample first
  ent_t         pend_q[$];
  int           pend_due[$];
  ent_t         sb_q[$];
  int           cyc = 0;
  bit           started = 0;

  always @(posedge clk) begin
    bit   s, p, ev, ev_e, do_pop;
    ent_t ent;
    cyc++;
    if (rst) begin
      m_cnt = '0; m_wrap = 0; m_ovf = 0; m_occ = 0; m_settle = S + 1;
      m_samp.delete();
      for (int i = 0; i <= S; i++) m_samp.push_back(1'b0);
      pend_q.delete(); pend_due.delete(); sb_q.delete();
      started = 1;
    end else if (started) begin
      // the delayed input and its previous value decide this cycle's edge
      s = m_samp[S-1];
      p = m_samp[S];
      ev = 0; ev_e = 0;
      if (ena && m_settle == 0) begin
        if (esel[0] && s && !p) begin ev = 1; ev_e = 1; end
        if (esel[1] && !s && p) begin ev = 1; ev_e = 0; end
      end
      if (clr) begin
        m_cnt = '0; m_wrap = 0; m_ovf = 0; m_occ = 0; m_settle = S + 1;
        pend_q.delete(); pend_due.delete(); sb_q.delete();
      end else begin
        do_pop = (m_occ > 0) && ready;
        if (pend_q.size() > 0 && pend_due[0] == cyc) begin
          ent = pend_q.pop_front();
          void'(pend_due.pop_front());
          if (m_occ < D || do_pop) begin
            sb_q.push_back(ent);
            m_occ++;
          end else begin
            m_ovf = 1;
          end
        end
        if (do_pop) m_occ--;
        if (ev) begin
          ent.e  = ev_e;
          ent.ts = m_cnt;
          pend_q.push_back(ent);
          pend_due.push_back(cyc + 1);
        end
        m_wrap = ena && (m_cnt == {W{1'b1}});
        if (ena) m_cnt = m_cnt + 1'b1;
        if (m_settle > 0) m_settle--;
      end
      m_samp.push_front(cap);
      void'(m_samp.pop_back());
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ent_t h;
    if (started) begin
      chk("value", value, m_cnt);
      chk("wrap", wrap, m_wrap);
      chk("ovf", ovf, m_ovf);
      chk("valid", cvalid, (m_occ > 0));
      if (cvalid && ready && !rst && !clr) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_empty: got data %0d edge %0d expected no entry", cdata, cedge);
        end else begin
          h = sb_q.pop_front();
          $display("pop t=%0t ts=%0d edge=%0d", $time, cdata, cedge);
          chk("cap_data", cdata, h.ts);
          chk("cap_edge", cedge, h.e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_value(input logic [W-1:0] v);
    int n = 0;
    while (value !== v && n < 600) begin
      step();
      n++;
    end
    chk("wait_value", value, v);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    logic [W-1:0] ts_a [6];
    logic         ed_a [6];
    int           n;

    rst = 1'b1; clr = 1'b0; ena = 1'b1; esel = 2'b11; cap = 1'b1; ready = 1'b1;
    step(); step();

    // 1: input already high through reset: nothing captured
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("settle_no_cap", cvalid, 1'b0);
    end

    // 2: rising edge latency and timestamp
    cap = 1'b0; esel = 2'b01; ready = 1'b1;
    do_clear();
    wait_value(9);
    cap = 1'b1;
    step();
    n = 0;
    while (!cvalid && n < 10) begin
      step();
      n++;
    end
    chk("lat_value", value, 13);
    chk("lat_data", cdata, 11);
    chk("lat_edge", cedge, 1'b1);
    cap = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (cvalid) n++;
    end
    chk("fall_ignored", n, 0);

    // 3: six edges into a four-entry FIFO with no consumer
    esel = 2'b11; ready = 1'b0; cap = 1'b0;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      cap = ~cap;
      step(); step();
    end
    repeat (4) step();
    chk("ovf_set", ovf, 1'b1);
    ready = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (cvalid && n < 6) begin
        ts_a[n] = cdata;
        ed_a[n] = cedge;
        n++;
      end
      step();
    end
    ready = 1'b0;
    chk("drain_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_edge", ed_a[i], (i % 2 == 0));
      if (i > 0) chk("drain_spacing", ts_a[i] - ts_a[i-1], 2);
    end
    chk("drain_empty", cvalid, 1'b0);

    // 4: full FIFO, push coincides with a pop
    cap = 1'b0;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      cap = ~cap;
      step(); step();
    end
    repeat (4) step();
    cap = ~cap;
    step(); step(); step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    chk("full_pop_ovf", ovf, 1'b0);
    ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (cvalid && n < 6) begin
        ed_a[n] = cedge;
        n++;
      end
      step();
    end
    ready = 1'b0;
    chk("full_pop_count", n, 4);
    chk("full_pop_last_edge", ed_a[3], 1'b1);

    // 5: wrap pulse and captures either side of the wrap
    cap = 1'b0;
    do_clear();
    wait_value(253);
    cap = 1'b1;
    step();
    cap = 1'b0;
    step();
    step();
    chk("wrap_value", value, 0);
    chk("wrap_pulse", wrap, 1'b1);
    step();
    chk("wrap_gone", wrap, 1'b0);
    step(); step();
    chk("wrap_cap_valid", cvalid, 1'b1);
    chk("wrap_cap_data0", cdata, 255);
    chk("wrap_cap_edge0", cedge, 1'b1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("wrap_cap_data1", cdata, 0);
    chk("wrap_cap_edge1", cedge, 1'b0);
    ready = 1'b1;
    step();
    ready = 1'b0;

    // 6: clear with three queued entries, then settle masking
    cap = 1'b0;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      cap = ~cap;
      step(); step();
    end
    repeat (4) step();
    chk("three_queued", cvalid, 1'b1);
    clr = 1'b1;
    cap = ~cap;
    step();
    clr = 1'b0;
    chk("clr_value", value, 0);
    chk("clr_valid", cvalid, 1'b0);
    chk("clr_ovf", ovf, 1'b0);
    repeat (6) step();
    chk("settle_masked", cvalid, 1'b0);
    cap = ~cap;
    repeat (5) step();
    chk("after_settle", cvalid, 1'b1);

    // 7: randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ena   = ($urandom_range(0, 9) != 0);
      esel  = 2'($urandom_range(0, 3));
      ready = ($urandom_range(0, 1) == 1);
      clr   = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 2) == 0) cap = ~cap;
      step();
    end
    clr = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_unit.md
# capture_unit

Input-capture block: the measuring counterpart to the compare timer. It timestamps edges on an asynchronous input against a free-running counter and queues each timestamp and its edge polarity in a small first-word-fall-through FIFO. The FIFO is drained through a valid/ready handshake. Software or a DMA front-end reads captures to measure period, pulse width or event times of external signals.

## Interface
- WIDTH, 32: counter and timestamp width.
- DEPTH, 4: capture FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2: input synchronizer flops; at least 2.

- clk_i  input  1  sole clock; every flop is on its rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- clr_i  input  1  synchronous clear of counter, FIFO, flags and settle logic.
- ena_i  input  1  counter increment and capture enable.
- edge_sel_i  input  2  00 none, 01 rising, 10 falling, 11 both.
- cap_i  input  1  asynchronous signal to timestamp.
- value_o  output  WIDTH  current counter value.
- wrap_o  output  1  one-cycle pulse on counter wrap.
- cap_data_o  output  WIDTH  timestamp at the FIFO head.
- cap_edge_o  output  1  polarity at the FIFO head; 1 = rising, 0 = falling.
- cap_valid_o  output  1  FIFO head valid.
- cap_ready_i  input  1  consumer accepts the head.
- ovf_o  output  1  sticky; at least one capture was lost because the FIFO was full.

## Operation
- Priority: rst_i > clr_i > normal operation.
- Counter:
  - When ena_i=1, value_o increments by 1 modulo 2^WIDTH; when ena_i=0 it holds.
  - wrap_o is registered. It is 1 for exactly the cycle in which value_o shows 0 after an increment from all-ones.
- Synchronizer and edge detector:
  - cap_i passes through SYNC_STAGES flops to s, then one more flop to p.
  - rise = s & ~p; fall = ~s & p.
  - An event is the rise or fall selected by edge_sel_i, gated by ena_i and by settle_done.
  - p always tracks s, including when ena_i=0, so a masked edge is never reported later.
- Settle logic:
  - After reset or clr_i, a counter suppresses events for SYNC_STAGES+1 cycles, then sets settle_done.
  - This prevents spurious edges while the chain fills.
- Capture: on an event, {edge, value_o} is pushed. The value is the value_o visible in the detection cycle, before that cycle's increment.
- FIFO:
  - Push and pop are both registered.
  - cap_valid_o = not empty.
  - A pop happens when cap_valid_o & cap_ready_i; the head advances at that clock edge.
- Full FIFO:
  - A push while full with no pop in the same cycle is dropped, and ovf_o is set.
  - A push while full with a simultaneous pop is accepted; ovf_o is unchanged.
- Empty FIFO: a push raises cap_valid_o in the next cycle. There is no same-cycle bypass.
- ovf_o clears only on rst_i or clr_i.
- cap_data_o and cap_edge_o are stable while cap_valid_o=1 and no pop occurs.
- Reset values: value_o=0, wrap_o=0, cap_valid_o=0, cap_data_o=0, cap_edge_o=0, ovf_o=0. Synchronizer flops, p, FIFO pointers and occupancy are 0; settle_done=0.
- clr_i mid-operation:
  - Same effect as reset on the counter, FIFO, ovf_o, wrap_o and settle logic.
  - The synchronizer keeps running, and p keeps tracking s.
  - Pending entries are discarded; cap_valid_o is 0 in the next cycle.

## Timing
- Capture latency: a cap_i transition first sampled at clock edge k gives s at edge k+SYNC_STAGES-1. The event is detected during the following cycle and written at edge k+SYNC_STAGES. With SYNC_STAGES=2, cap_valid_o rises 3 clocks after sampling.
- Timestamp: the value_o seen between edges k+SYNC_STAGES-1 and k+SYNC_STAGES.
- Throughput: one push and one pop per cycle. Minimum detectable pulse is one clock high plus one clock low at cap_i.
- Sustained event rate: equal to the pop rate with no loss.
- wrap_o and counter updates take effect at the same edge.

## Test plan
- Reset, release, hold cap_i=1 with ena_i=1, edge_sel_i=11: no capture; cap_valid_o=0 throughout settle and afterwards.
- edge_sel_i=01, ena_i=1, cap_ready_i=1: a rising cap_i sampled when value_o=10 gives cap_valid_o at the edge where value_o=13, with cap_data_o=11 and cap_edge_o=1. Falling edges produce nothing.
- edge_sel_i=11, cap_ready_i=0, DEPTH=4, six edges:
  - Four entries queued in order; ovf_o=1 after the fifth edge.
  - Draining gives the four original timestamps and alternating polarity, then cap_valid_o=0.
- FIFO full, an event coincides with cap_ready_i=1: entry accepted, ovf_o stays 0, occupancy stays 4.
- Force value_o toward all-ones by running the counter from clear: wrap_o is one cycle high when value_o=0, and a capture across the wrap records all-ones or 0 correctly.
- With three queued entries, assert clr_i for one cycle: next cycle value_o=0, cap_valid_o=0, ovf_o=0. A new edge is ignored until settle completes, then captured.
